// File: rtl/tick_sequencer_if.sv
// rtl/tick_sequencer_if.sv - shared map-lookup port between VGA engine, sequencer and map storage
// The sequencer side (master) owns the muxed address; storage returns i_is_wall.
interface tick_sequencer_if;
   logic [5:0] i_vga_x;
   logic [5:0] i_vga_y;
   logic [5:0] o_map_x;
   logic [5:0] o_map_y;
   logic       i_is_wall;

   modport master (
      input  i_vga_x,
      input  i_vga_y,
      input  i_is_wall,
      output o_map_x,
      output o_map_y
   );

   modport slave (
      output i_vga_x,
      output i_vga_y,
      output i_is_wall,
      input  o_map_x,
      input  o_map_y
   );
endinterface

// File: rtl/tick_sequencer.sv
// rtl/tick_sequencer.sv - per-tick tank move check, conflict resolution and commit pulses
// Runs once every TICK_FRAMES frames at blanking start; borrows the map port only while VGA is idle.
module tick_sequencer #(
   parameter int         TICK_FRAMES = 4,
   parameter int         MAP_LAT     = 1,
   parameter int         MAP_W       = 40,
   parameter int         MAP_H       = 30,
   parameter logic [1:0] PLAY_STATE  = 2'd1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       i_state,
   input  logic             i_busy,
   tick_sequencer_if.master map_bus,
   input  logic [5:0]       i_t1_x,
   input  logic [5:0]       i_t1_y,
   input  logic [5:0]       i_t2_x,
   input  logic [5:0]       i_t2_y,
   input  logic [2:0]       i_req_1,
   input  logic [2:0]       i_req_2,
   output logic             o_frame_1,
   output logic             o_frame_2,
   output logic             o_move_1,
   output logic             o_move_2,
   output logic [1:0]       o_dir_1,
   output logic [1:0]       o_dir_2,
   output logic             o_shell_step,
   output logic             o_seq_active
);

   localparam int             FCW    = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
   localparam logic [FCW-1:0] F_LAST = FCW'(TICK_FRAMES - 1);
   localparam logic [1:0]     L_LAST = 2'(MAP_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_Q1, S_R1, S_Q2, S_R2, S_COMMIT, S_SHELL
   } state_t;

   typedef struct packed {
      logic       ok;
      logic [5:0] x;
      logic [5:0] y;
   } cell_t;

   // Out-of-range moves report ok=0 and keep the current cell as the address.
   function automatic cell_t step_cell(input logic [5:0] x, input logic [5:0] y,
                                       input logic [1:0] dir);
      cell_t c;
      c.ok = 1'b1;
      c.x  = x;
      c.y  = y;
      case (dir)
         2'd0:    if (y == 6'd0) c.ok = 1'b0; else c.y = y - 6'd1;
         2'd1:    if (y >= 6'(MAP_H - 1)) c.ok = 1'b0; else c.y = y + 6'd1;
         2'd2:    if (x == 6'd0) c.ok = 1'b0; else c.x = x - 6'd1;
         default: if (x >= 6'(MAP_W - 1)) c.ok = 1'b0; else c.x = x + 6'd1;
      endcase
      return c;
   endfunction

   state_t         state_q, state_d;
   logic [FCW-1:0] frame_q, frame_d;
   logic [1:0]     lat_q, lat_d;
   logic           busy_q;
   logic [5:0]     t1x_q, t1x_d, t1y_q, t1y_d, t2x_q, t2x_d, t2y_q, t2y_d;
   logic [2:0]     req1_q, req1_d, req2_q, req2_d;
   logic           ok1_q, ok1_d, ok2_q, ok2_d;

   logic           busy_fall;
   logic           seq_act;
   logic [5:0]     seq_x, seq_y;
   logic           same_tgt, hit1, hit2;
   cell_t          tgt1, tgt2;

   assign busy_fall = busy_q & ~i_busy;
   assign tgt1      = step_cell(t1x_q, t1y_q, req1_q[1:0]);
   assign tgt2      = step_cell(t2x_q, t2y_q, req2_q[1:0]);

   assign same_tgt  = req1_q[2] & req2_q[2] & (tgt1.x == tgt2.x) & (tgt1.y == tgt2.y);
   assign hit1      = (tgt1.x == t2x_q) & (tgt1.y == t2y_q);
   assign hit2      = (tgt2.x == t1x_q) & (tgt2.y == t1y_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         frame_q <= '0;
         lat_q   <= 2'd0;
         busy_q  <= 1'b0;
         t1x_q   <= 6'd0;
         t1y_q   <= 6'd0;
         t2x_q   <= 6'd0;
         t2y_q   <= 6'd0;
         req1_q  <= 3'd0;
         req2_q  <= 3'd0;
         ok1_q   <= 1'b0;
         ok2_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         lat_q   <= lat_d;
         busy_q  <= i_busy;
         t1x_q   <= t1x_d;
         t1y_q   <= t1y_d;
         t2x_q   <= t2x_d;
         t2y_q   <= t2y_d;
         req1_q  <= req1_d;
         req2_q  <= req2_d;
         ok1_q   <= ok1_d;
         ok2_q   <= ok2_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      frame_d      = frame_q;
      lat_d        = lat_q;
      t1x_d        = t1x_q;
      t1y_d        = t1y_q;
      t2x_d        = t2x_q;
      t2y_d        = t2y_q;
      req1_d       = req1_q;
      req2_d       = req2_q;
      ok1_d        = ok1_q;
      ok2_d        = ok2_q;
      seq_act      = 1'b0;
      seq_x        = tgt1.x;
      seq_y        = tgt1.y;
      o_frame_1    = 1'b0;
      o_frame_2    = 1'b0;
      o_move_1     = 1'b0;
      o_move_2     = 1'b0;
      o_dir_1      = 2'd0;
      o_dir_2      = 2'd0;
      o_shell_step = 1'b0;

      case (state_q)
         S_IDLE: begin
            frame_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (busy_fall) begin
               if (frame_q == F_LAST) begin
                  frame_d = '0;
                  lat_d   = 2'd0;
                  state_d = S_Q1;
                  t1x_d   = i_t1_x;
                  t1y_d   = i_t1_y;
                  t2x_d   = i_t2_x;
                  t2y_d   = i_t2_y;
                  req1_d  = i_req_1;
                  req2_d  = i_req_2;
               end else begin
                  frame_d = frame_q + 1'b1;
               end
            end
         end
         S_Q1: begin
            seq_act = 1'b1;
            lat_d   = lat_q + 2'd1;
            if (lat_q == L_LAST) begin
               lat_d   = 2'd0;
               state_d = S_R1;
            end
         end
         S_R1: begin
            seq_act = 1'b1;
            ok1_d   = req1_q[2] & tgt1.ok & ~map_bus.i_is_wall;
            state_d = S_Q2;
         end
         S_Q2: begin
            seq_act = 1'b1;
            seq_x   = tgt2.x;
            seq_y   = tgt2.y;
            lat_d   = lat_q + 2'd1;
            if (lat_q == L_LAST) begin
               lat_d   = 2'd0;
               state_d = S_R2;
            end
         end
         S_R2: begin
            seq_act = 1'b1;
            seq_x   = tgt2.x;
            seq_y   = tgt2.y;
            ok2_d   = req2_q[2] & tgt2.ok & ~map_bus.i_is_wall;
            state_d = S_COMMIT;
         end
         S_COMMIT: begin
            o_frame_1 = 1'b1;
            o_frame_2 = 1'b1;
            o_move_1  = ok1_q & ~same_tgt & ~hit1;
            o_move_2  = ok2_q & ~same_tgt & ~hit2;
            o_dir_1   = req1_q[2] ? req1_q[1:0] : 2'd0;
            o_dir_2   = req2_q[2] ? req2_q[1:0] : 2'd0;
            state_d   = S_SHELL;
         end
         default: begin
            o_shell_step = 1'b1;
            state_d      = S_WAIT;
         end
      endcase

      // VGA reclaiming the port mid-query: retry on the very next blanking.
      if (seq_act && i_busy) begin
         seq_act = 1'b0;
         lat_d   = 2'd0;
         frame_d = F_LAST;
         state_d = S_WAIT;
      end

      if (i_state != PLAY_STATE) begin
         frame_d = '0;
         state_d = S_IDLE;
      end
   end

   assign o_seq_active    = seq_act;
   assign map_bus.o_map_x = seq_act ? seq_x : map_bus.i_vga_x;
   assign map_bus.o_map_y = seq_act ? seq_y : map_bus.i_vga_y;

endmodule

// File: tb/tb_tick_sequencer.sv
// tb/tb_tick_sequencer.sv - directed bench for tick_sequencer (TICK_FRAMES=4, MAP_LAT=1)
// A one-cycle registered map model supplies i_is_wall for a single configurable wall cell.
module tb_tick_sequencer;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] i_state;
   logic       i_busy;
   logic [5:0] i_t1_x, i_t1_y, i_t2_x, i_t2_y;
   logic [2:0] i_req_1, i_req_2;
   logic       o_frame_1, o_frame_2, o_move_1, o_move_2, o_shell_step, o_seq_active;
   logic [1:0] o_dir_1, o_dir_2;
   logic       wall_en;
   logic [5:0] wall_x, wall_y;

   int         vectors = 0;
   int         miscompares = 0;
   int         stray;
   int         cap_lat_f, cap_lat_s;
   logic       cap_mv1, cap_mv2, cap_f2, cap_act;
   logic [1:0] cap_d1, cap_d2;
   logic [5:0] cap_qx, cap_qy;

   tick_sequencer_if mif();

   tick_sequencer #(
      .TICK_FRAMES(4), .MAP_LAT(1), .MAP_W(40), .MAP_H(30), .PLAY_STATE(2'd1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_state(i_state), .i_busy(i_busy), .map_bus(mif),
      .i_t1_x(i_t1_x), .i_t1_y(i_t1_y), .i_t2_x(i_t2_x), .i_t2_y(i_t2_y),
      .i_req_1(i_req_1), .i_req_2(i_req_2),
      .o_frame_1(o_frame_1), .o_frame_2(o_frame_2), .o_move_1(o_move_1), .o_move_2(o_move_2),
      .o_dir_1(o_dir_1), .o_dir_2(o_dir_2), .o_shell_step(o_shell_step),
      .o_seq_active(o_seq_active)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      mif.i_is_wall <= wall_en && (mif.o_map_x == wall_x) && (mif.o_map_y == wall_y);

   // One VGA frame: busy for 3 cycles, then 12 blanking cycles observed at negedges.
   task automatic blank_frame(input bit scramble);
      cap_lat_f = 0; cap_lat_s = 0;
      cap_mv1 = 0; cap_mv2 = 0; cap_d1 = 0; cap_d2 = 0; cap_f2 = 0;
      cap_qx = 0; cap_qy = 0; cap_act = 0;
      @(negedge clk) i_busy = 1'b1;
      repeat (3) @(negedge clk);
      i_busy = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (i == 1) begin
            cap_qx = mif.o_map_x; cap_qy = mif.o_map_y; cap_act = o_seq_active;
            if (scramble) begin i_req_1 = 3'b010; i_t1_x = 6'd0; end
         end
         if (o_frame_1 && cap_lat_f == 0) begin
            cap_lat_f = i; cap_mv1 = o_move_1; cap_mv2 = o_move_2;
            cap_d1 = o_dir_1; cap_d2 = o_dir_2; cap_f2 = o_frame_2;
         end
         if (o_shell_step && cap_lat_s == 0) cap_lat_s = i;
      end
   endtask

   task automatic run_frames(input int n);
      stray = 0;
      for (int f = 0; f < n; f++) begin
         blank_frame(1'b0);
         if (cap_lat_f != 0 || cap_lat_s != 0) stray++;
      end
   endtask

   task automatic do_tick(input bit scramble);
      run_frames(3);
      blank_frame(scramble);
   endtask

   task automatic set_tanks(input logic [5:0] x1, y1, input logic [2:0] r1,
                            input logic [5:0] x2, y2, input logic [2:0] r2);
      @(negedge clk);
      i_t1_x = x1; i_t1_y = y1; i_req_1 = r1;
      i_t2_x = x2; i_t2_y = y2; i_req_2 = r2;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; i_state = 2'd1; i_busy = 1'b0;
      mif.i_vga_x = 6'd5; mif.i_vga_y = 6'd7;
      i_t1_x = 0; i_t1_y = 0; i_t2_x = 0; i_t2_y = 0; i_req_1 = 0; i_req_2 = 0;
      wall_en = 1'b0; wall_x = 0; wall_y = 0;
      repeat (3) @(negedge clk);
      vectors++; if (mif.o_map_x !== 6'd5) begin miscompares++; $display("FAIL reset_map_x: got %0d expected 5", mif.o_map_x); end
      vectors++; if (mif.o_map_y !== 6'd7) begin miscompares++; $display("FAIL reset_map_y: got %0d expected 7", mif.o_map_y); end
      vectors++; if ({o_frame_1, o_frame_2, o_shell_step, o_seq_active} !== 4'b0000) begin miscompares++; $display("FAIL reset_pulses: got %b expected 0000", {o_frame_1, o_frame_2, o_shell_step, o_seq_active}); end
      vectors++; if ({o_move_1, o_move_2, o_dir_1, o_dir_2} !== 6'd0) begin miscompares++; $display("FAIL reset_moves: got %b expected 000000", {o_move_1, o_move_2, o_dir_1, o_dir_2}); end
      rst_n = 1'b1;
      run_frames(3);
      vectors++; if (stray !== 0) begin miscompares++; $display("FAIL reset_early_tick: got %0d pulsed frames expected 0", stray); end
   endtask

   task automatic test_free_move();
      set_tanks(6'd10, 6'd10, 3'b111, 6'd30, 6'd20, 3'b000);
      blank_frame(1'b0);
      vectors++; if (cap_lat_f !== 5) begin miscompares++; $display("FAIL free_frame_lat: got %0d expected 5", cap_lat_f); end
      vectors++; if (cap_lat_s !== 6) begin miscompares++; $display("FAIL free_shell_lat: got %0d expected 6", cap_lat_s); end
      vectors++; if (cap_f2 !== 1'b1) begin miscompares++; $display("FAIL free_frame_2: got %b expected 1", cap_f2); end
      vectors++; if ({cap_mv1, cap_d1} !== 3'b111) begin miscompares++; $display("FAIL free_move_1: got %b expected 111", {cap_mv1, cap_d1}); end
      vectors++; if ({cap_mv2, cap_d2} !== 3'b000) begin miscompares++; $display("FAIL free_move_2: got %b expected 000", {cap_mv2, cap_d2}); end
      vectors++; if ({cap_act, cap_qx, cap_qy} !== {1'b1, 6'd11, 6'd10}) begin miscompares++; $display("FAIL free_q1_addr: got act=%b (%0d,%0d) expected act=1 (11,10)", cap_act, cap_qx, cap_qy); end
      mif.i_vga_x = 6'd12; mif.i_vga_y = 6'd13;
      #1;
      vectors++; if ({mif.o_map_x, mif.o_map_y} !== {6'd12, 6'd13}) begin miscompares++; $display("FAIL mux_vga: got (%0d,%0d) expected (12,13)", mif.o_map_x, mif.o_map_y); end
   endtask

   task automatic test_wall_edge();
      wall_en = 1'b1; wall_x = 6'd3; wall_y = 6'd2;
      set_tanks(6'd0, 6'd4, 3'b110, 6'd3, 6'd3, 3'b100);
      do_tick(1'b0);
      vectors++; if (stray !== 0) begin miscompares++; $display("FAIL wall_stray: got %0d expected 0", stray); end
      vectors++; if ({cap_mv1, cap_d1} !== 3'b010) begin miscompares++; $display("FAIL left_edge_1: got %b expected 010", {cap_mv1, cap_d1}); end
      vectors++; if ({cap_mv2, cap_d2} !== 3'b000) begin miscompares++; $display("FAIL wall_up_2: got %b expected 000", {cap_mv2, cap_d2}); end
      set_tanks(6'd39, 6'd0, 3'b111, 6'd3, 6'd29, 3'b101);
      do_tick(1'b0);
      vectors++; if ({cap_mv1, cap_d1} !== 3'b011) begin miscompares++; $display("FAIL right_edge_1: got %b expected 011", {cap_mv1, cap_d1}); end
      vectors++; if ({cap_mv2, cap_d2} !== 3'b001) begin miscompares++; $display("FAIL bottom_edge_2: got %b expected 001", {cap_mv2, cap_d2}); end
      set_tanks(6'd20, 6'd0, 3'b100, 6'd3, 6'd3, 3'b101);
      do_tick(1'b0);
      vectors++; if ({cap_mv1, cap_d1} !== 3'b000) begin miscompares++; $display("FAIL top_edge_1: got %b expected 000", {cap_mv1, cap_d1}); end
      vectors++; if ({cap_mv2, cap_d2} !== 3'b101) begin miscompares++; $display("FAIL clear_down_2: got %b expected 101", {cap_mv2, cap_d2}); end
      wall_en = 1'b0;
   endtask

   task automatic test_conflict();
      set_tanks(6'd5, 6'd5, 3'b111, 6'd7, 6'd5, 3'b110);
      do_tick(1'b0);
      vectors++; if ({cap_mv1, cap_d1, cap_mv2, cap_d2} !== 6'b011010) begin miscompares++; $display("FAIL same_target: got %b expected 011010", {cap_mv1, cap_d1, cap_mv2, cap_d2}); end
      set_tanks(6'd5, 6'd5, 3'b111, 6'd6, 6'd5, 3'b000);
      do_tick(1'b0);
      vectors++; if ({cap_mv1, cap_d1, cap_mv2, cap_d2} !== 6'b011000) begin miscompares++; $display("FAIL into_tank_2: got %b expected 011000", {cap_mv1, cap_d1, cap_mv2, cap_d2}); end
      set_tanks(6'd5, 6'd5, 3'b000, 6'd6, 6'd5, 3'b110);
      do_tick(1'b0);
      vectors++; if ({cap_mv1, cap_d1, cap_mv2, cap_d2} !== 6'b000010) begin miscompares++; $display("FAIL into_tank_1: got %b expected 000010", {cap_mv1, cap_d1, cap_mv2, cap_d2}); end
   endtask

   task automatic test_abort();
      int pulses;
      set_tanks(6'd10, 6'd10, 3'b111, 6'd20, 6'd20, 3'b101);
      run_frames(3);
      vectors++; if (stray !== 0) begin miscompares++; $display("FAIL abort_stray: got %0d expected 0", stray); end
      @(negedge clk) i_busy = 1'b1;
      repeat (3) @(negedge clk);
      i_busy = 1'b0;
      repeat (3) @(negedge clk);
      i_busy = 1'b1;
      #1;
      vectors++; if ({o_seq_active, mif.o_map_x, mif.o_map_y} !== {1'b0, 6'd12, 6'd13}) begin miscompares++; $display("FAIL abort_release: got act=%b (%0d,%0d) expected act=0 (12,13)", o_seq_active, mif.o_map_x, mif.o_map_y); end
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (o_frame_1 || o_frame_2 || o_shell_step) pulses++;
      end
      vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL abort_pulses: got %0d expected 0", pulses); end
      blank_frame(1'b0);
      vectors++; if (cap_lat_f !== 5) begin miscompares++; $display("FAIL retry_lat: got %0d expected 5", cap_lat_f); end
      vectors++; if ({cap_mv1, cap_d1, cap_mv2, cap_d2} !== 6'b111101) begin miscompares++; $display("FAIL retry_moves: got %b expected 111101", {cap_mv1, cap_d1, cap_mv2, cap_d2}); end
   endtask

   task automatic test_state_exit();
      run_frames(2);
      vectors++; if (stray !== 0) begin miscompares++; $display("FAIL exit_pre: got %0d expected 0", stray); end
      @(negedge clk) i_state = 2'd2;
      run_frames(3);
      vectors++; if (stray !== 0) begin miscompares++; $display("FAIL exit_idle: got %0d expected 0", stray); end
      @(negedge clk) i_state = 2'd1;
      run_frames(3);
      vectors++; if (stray !== 0) begin miscompares++; $display("FAIL exit_restart: got %0d expected 0", stray); end
      blank_frame(1'b0);
      vectors++; if (cap_lat_f !== 5) begin miscompares++; $display("FAIL exit_tick_lat: got %0d expected 5", cap_lat_f); end
   endtask

   task automatic test_back_to_back();
      set_tanks(6'd10, 6'd10, 3'b111, 6'd30, 6'd20, 3'b000);
      do_tick(1'b1);
      vectors++; if ({cap_mv1, cap_d1} !== 3'b111) begin miscompares++; $display("FAIL latch_hold: got %b expected 111", {cap_mv1, cap_d1}); end
      do_tick(1'b0);
      vectors++; if ({cap_lat_f, cap_mv1, cap_d1} !== {32'd5, 3'b000}) begin miscompares++; $display("FAIL second_tick: got lat=%0d %b expected lat=5 000", cap_lat_f, {cap_mv1, cap_d1}); end
   endtask

   task automatic test_reset_mid();
      int pulses;
      set_tanks(6'd10, 6'd10, 3'b111, 6'd30, 6'd20, 3'b000);
      run_frames(3);
      @(negedge clk) i_busy = 1'b1;
      repeat (3) @(negedge clk);
      i_busy = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      vectors++; if ({o_seq_active, o_frame_1, o_shell_step, mif.o_map_x} !== {3'b000, 6'd12}) begin miscompares++; $display("FAIL mid_reset: got act=%b f=%b s=%b x=%0d expected 0 0 0 12", o_seq_active, o_frame_1, o_shell_step, mif.o_map_x); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (o_frame_1 || o_frame_2 || o_shell_step) pulses++;
      end
      vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL mid_reset_pulses: got %0d expected 0", pulses); end
   endtask

   initial begin
      test_reset();
      test_free_move();
      test_wall_edge();
      test_conflict();
      test_abort();
      test_state_exit();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded, got no end expected end");
      $fatal(1);
   end
endmodule
